seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 206 ++++++++++++++++++++
 tb/tb_seq_divider.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Function : Iterative radix-2 restoring divider. It takes one dividend/divisor
//            pair on two valid-qualified streams and returns
//            {quotient, remainder} on a single valid-qualified stream.
//            The divide runs for WIDTH cycles and can be signed or unsigned.
// Options  : SEQ_DIVIDER_DIVZERO_FLAG_EN adds output m_axis_dout_tuser, which
//            is set when the divisor was zero.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 1
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               aclken,
  input  logic               s_axis_divisor_tvalid,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_dividend_tvalid,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
`ifdef SEQ_DIVIDER_DIVZERO_FLAG_EN
  output logic               m_axis_dout_tuser,
`endif
  output logic               busy
);

  // Counter is wide enough to hold WIDTH-1 (at least one bit).
  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  localparam logic [2:0] c_idle = 3'd0;
  localparam logic [2:0] c_prep = 3'd1;
  localparam logic [2:0] c_iter = 3'd2;
  localparam logic [2:0] c_fix  = 3'd3;
  localparam logic [2:0] c_done = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic               w_accept;

  // Raw operands as accepted. The raw dividend also serves as the
  // divide-by-zero remainder.
  logic [WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]   r_divisor;

  // Working datapath. r_quo starts as the dividend magnitude. Each step
  // shifts one dividend bit out of the top and one quotient bit in at the
  // bottom.
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvs;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_divzero;

  logic [2*WIDTH-1:0] r_tdata;
  logic               r_tuser;

  logic               w_neg_dvd;
  logic               w_neg_dvs;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  // For an unsigned divide, operand sign bits are ordinary magnitude bits.
  generate
    if (SIGNED != 0) begin : g_signed
      assign w_neg_dvd = r_dividend[WIDTH-1];
      assign w_neg_dvs = r_divisor[WIDTH-1];
    end else begin : g_unsigned
      assign w_neg_dvd = 1'b0;
      assign w_neg_dvs = 1'b0;
    end
  endgenerate

  // Two's-complement magnitude. The most negative value maps onto
  // 2^(WIDTH-1), which is still representable as an unsigned value.
  assign w_dvd_mag = w_neg_dvd ? (-r_dividend) : r_dividend;
  assign w_dvs_mag = w_neg_dvs ? (-r_divisor)  : r_divisor;

  // One restoring step. The shifted remainder needs WIDTH+1 bits. After a
  // subtract, the result is below the divisor, so the low WIDTH bits are exact.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;

  // Sign correction: truncate toward zero, remainder follows the dividend.
  // A zero divisor overrides both fields.
  always_comb begin
    w_q_fix = r_sign_q ? (-r_quo) : r_quo;
    w_r_fix = r_sign_r ? (-r_rem) : r_rem;
    if (r_divzero) begin
      w_q_fix = '1;
      w_r_fix = r_dividend;
    end
  end

  // FSM state register; freezes while the clock enable is low.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= c_idle;
    end else if (aclken) begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: fixed walk from PREP through DONE once an operation starts.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      c_idle:  if (w_accept) w_next_state = c_prep;
      c_prep:  w_next_state = c_iter;
      c_iter:  if (r_cnt == '0) w_next_state = c_fix;
      c_fix:   w_next_state = c_done;
      c_done:  w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // FSM outputs: accept strobe, result valid and busy, all decoded from state.
  always_comb begin
    w_accept           = 1'b0;
    m_axis_dout_tvalid = 1'b0;
    busy               = 1'b1;
    unique case (r_state)
      c_idle: begin
        busy     = 1'b0;
        w_accept = s_axis_divisor_tvalid & s_axis_dividend_tvalid;
      end
      c_done:  m_axis_dout_tvalid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch operands, prepare magnitudes and signs, then iterate.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_cnt      <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_divzero  <= 1'b0;
    end else if (aclken) begin
      unique case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_dividend <= s_axis_dividend_tdata;
            r_divisor  <= s_axis_divisor_tdata;
          end
        end
        c_prep: begin
          r_sign_q  <= w_neg_dvd ^ w_neg_dvs;
          r_sign_r  <= w_neg_dvd;
          r_quo     <= w_dvd_mag;
          r_dvs     <= w_dvs_mag;
          r_rem     <= '0;
          r_divzero <= (r_divisor == '0);
          r_cnt     <= c_cnt_last;
        end
        c_iter: begin
          r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - c_cnt_one;
        end
        default: ;
      endcase
    end
  end

  // Result register: loaded on the FIX->DONE edge, then held until the next result.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_tdata <= '0;
      r_tuser <= 1'b0;
    end else if (aclken && (r_state == c_fix)) begin
      r_tdata <= {w_q_fix, w_r_fix};
      r_tuser <= r_divzero;
    end
  end

  assign m_axis_dout_tdata = r_tdata;

`ifdef SEQ_DIVIDER_DIVZERO_FLAG_EN
  assign m_axis_dout_tuser = r_tuser;
`else
  // Without the flag port, the zero-divisor indication has no consumer.
  logic w_tuser_unused;
  assign w_tuser_unused = r_tuser;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Function : Scoreboard bench for seq_divider. The signed and unsigned
//            instances share one input stream. A timing/arithmetic model
//            predicts accepts and results, and a monitor compares outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          aclken = 1'b1;
  logic          dvs_v = 1'b0;
  logic          dvd_v = 1'b0;
  logic [W-1:0]  dvs_d = '0;
  logic [W-1:0]  dvd_d = '0;

  logic          tv_s, busy_s, tv_u, busy_u;
  logic [2*W-1:0] td_s, td_u;
`ifdef SEQ_DIVIDER_DIVZERO_FLAG_EN
  logic          tu_s, tu_u;
`endif

  seq_divider #(.WIDTH(W), .SIGNED(1)) u_dut_s (
    .clk                    (clk),
    .aresetn                (aresetn),
    .aclken                 (aclken),
    .s_axis_divisor_tvalid  (dvs_v),
    .s_axis_divisor_tdata   (dvs_d),
    .s_axis_dividend_tvalid (dvd_v),
    .s_axis_dividend_tdata  (dvd_d),
    .m_axis_dout_tvalid     (tv_s),
    .m_axis_dout_tdata      (td_s),
`ifdef SEQ_DIVIDER_DIVZERO_FLAG_EN
    .m_axis_dout_tuser      (tu_s),
`endif
    .busy                   (busy_s)
  );

  seq_divider #(.WIDTH(W), .SIGNED(0)) u_dut_u (
    .clk                    (clk),
    .aresetn                (aresetn),
    .aclken                 (aclken),
    .s_axis_divisor_tvalid  (dvs_v),
    .s_axis_divisor_tdata   (dvs_d),
    .s_axis_dividend_tvalid (dvd_v),
    .s_axis_dividend_tdata  (dvd_d),
    .m_axis_dout_tvalid     (tv_u),
    .m_axis_dout_tdata      (td_u),
`ifdef SEQ_DIVIDER_DIVZERO_FLAG_EN
    .m_axis_dout_tuser      (tu_u),
`endif
    .busy                   (busy_u)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] d_s;
    logic [2*W-1:0] d_u;
    logic           z;
    int unsigned    due;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned en_cnt    = 0;
  int unsigned next_free = 0;
  int unsigned acc_e     = 0;
  bit          have_op   = 1'b0;
  int unsigned last_pop  = 32'hFFFF_FFFF;
  logic [2*W-1:0] last_s = '0;
  logic [2*W-1:0] last_u = '0;
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
  endtask

  // Arithmetic reference: 64-bit division avoids the -2^31/-1 overflow trap,
  // and truncating the result to 32 bits gives the required wrap.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    longint sa, sb, q, r;
    if (b == '0) return {{W{1'b1}}, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {q[W-1:0], r[W-1:0]};
  endfunction

  // Transaction-level model. It counts enabled edges. A pair is accepted
  // when both valids are high and the previous op has finished
  // (WIDTH+4 enabled edges apart). The result is due WIDTH+2 enabled edges
  // after the accept.
  always @(posedge clk) begin
    if (!aresetn) begin
      exp_q.delete();
      have_op   = 1'b0;
      next_free = en_cnt;
      last_s    = '0;
      last_u    = '0;
    end else if (aclken) begin
      en_cnt++;
      if (dvs_v && dvd_v && en_cnt >= next_free) begin
        exp_t e;
        e.d_s = ref_div(dvd_d, dvs_d, 1'b1);
        e.d_u = ref_div(dvd_d, dvs_d, 1'b0);
        e.z   = (dvs_d == '0);
        e.due = en_cnt + W + 2;
        exp_q.push_back(e);
        have_op   = 1'b1;
        acc_e     = en_cnt;
        next_free = en_cnt + W + 4;
      end
    end
  end

  // Monitor: check busy and tvalid against the model's timing.
  // On each new pulse, pop the scoreboard and compare; between pulses,
  // check that tdata holds.
  always @(negedge clk) begin : mon
    logic exp_tv, exp_busy;
    exp_t e;
    if (aresetn) begin
      exp_tv   = have_op && (en_cnt == acc_e + W + 2);
      exp_busy = have_op && (en_cnt <= acc_e + W + 2);
      check("busy_s",   {63'd0, busy_s}, {63'd0, exp_busy});
      check("busy_u",   {63'd0, busy_u}, {63'd0, exp_busy});
      check("tvalid_s", {63'd0, tv_s},   {63'd0, exp_tv});
      check("tvalid_u", {63'd0, tv_u},   {63'd0, exp_tv});
      if (tv_s && en_cnt != last_pop) begin
        last_pop = en_cnt;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result: got tvalid=1 required no pending op (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("tdata_s", td_s, e.d_s);
          check("tdata_u", td_u, e.d_u);
          check("latency", 64'(en_cnt), 64'(e.due));
`ifdef SEQ_DIVIDER_DIVZERO_FLAG_EN
          check("tuser_s", {63'd0, tu_s}, {63'd0, e.z});
          check("tuser_u", {63'd0, tu_u}, {63'd0, e.z});
`endif
          last_s = e.d_s;
          last_u = e.d_u;
        end
      end else if (!tv_s) begin
        check("hold_s", td_s, last_s);
        check("hold_u", td_u, last_u);
      end
    end
  end

  // Wait (bounded) until the next enabled edge may accept a new pair.
  task automatic wait_idle();
    int n = 0;
    while (en_cnt + 1 < next_free && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      $display("FAIL wait_idle: got still busy after %0d cycles required idle", n);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    dvd_d = a; dvs_d = b; dvd_v = 1'b1; dvs_v = 1'b1;
    @(negedge clk);
    dvd_v = 1'b0; dvs_v = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd32();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tvalid", {63'd0, tv_s},   64'd0);
    check("rst_busy",   {63'd0, busy_s}, 64'd0);
    check("rst_tdata",  td_s,            64'd0);
    aresetn = 1'b1;
    @(negedge clk);

    // Directed operands
    issue(32'd100, 32'd7);
    issue(32'hFFFF_FF9C, 32'd7);
    issue(32'd100, 32'hFFFF_FFF9);
    issue(32'd5, 32'd0);
    issue(32'd9, 32'd3);
    issue(32'h8000_0000, 32'hFFFF_FFFF);

    // Clock-enable stall mid-ITER, with pairs offered while busy
    issue(32'd100, 32'd7);
    repeat (8) @(negedge clk);
    aclken = 1'b0;
    dvd_d = 32'd77; dvs_d = 32'd5; dvd_v = 1'b1; dvs_v = 1'b1;
    repeat (5) @(negedge clk);
    aclken = 1'b1;
    repeat (3) @(negedge clk);
    dvd_v = 1'b0; dvs_v = 1'b0;
    wait_idle();

    // Lone dividend valid in IDLE
    dvd_d = 32'd50; dvd_v = 1'b1;
    @(negedge clk);
    dvd_v = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of an operation
    issue(32'd100, 32'd7);
    repeat (12) @(negedge clk);
    #1 aresetn = 1'b0;
    #1;
    check("arst_tvalid", {63'd0, tv_s},   64'd0);
    check("arst_busy",   {63'd0, busy_s}, 64'd0);
    check("arst_tdata",  td_s,            64'd0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    issue(32'd9, 32'd3);
    wait_idle();

    // Randomized traffic: enable gaps, lone valids, pairs while busy
    for (int i = 0; i < 4000; i++) begin
      aclken = ($urandom_range(0, 7) != 0);
      dvd_v  = ($urandom_range(0, 3) != 0);
      dvs_v  = ($urandom_range(0, 3) != 0);
      dvd_d  = rnd32();
      dvs_d  = rnd32();
      @(negedge clk);
    end

    // Drain
    aclken = 1'b1; dvd_v = 1'b0; dvs_v = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
